// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - two-wire serial program-memory loader that holds the core in reset while programming.
// Defining PROG_VERIFY_EN adds READ_DATA (0x04) read-back on icspDataOut.
module prog_loader #(
  parameter int ADDR_WIDTH = 9,
  parameter int WORD_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  progEn,
  input  logic                  icspClk,
  input  logic                  icspData,
`ifdef PROG_VERIFY_EN
  input  logic [WORD_WIDTH-1:0] memRdData,
  output logic                  icspDataOut,
`endif
  output logic                  memWrEn,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [WORD_WIDTH-1:0] memWrData,
  output logic                  coreHold,
  output logic                  frameErr
);

  localparam int FRAME_W = WORD_WIDTH + 4;
  localparam logic [5:0] OP_RADDR = 6'h00;
  localparam logic [5:0] OP_LOAD  = 6'h02;
  localparam logic [5:0] OP_INC   = 6'h06;
  localparam logic [5:0] OP_BEGIN = 6'h08;
`ifdef PROG_VERIFY_EN
  localparam logic [5:0] OP_READ  = 6'h04;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_DATA, S_EXEC
`ifdef PROG_VERIFY_EN
    , S_RDOUT
`endif
  } state_t;

  state_t                state_q, state_d;
  logic                  prog_s1_q, prog_s2_q;
  logic                  clk_s1_q, clk_s2_q, clk_s3_q;
  logic                  dat_s1_q, dat_s2_q;
  logic [FRAME_W-1:0]    sh_q, sh_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [5:0]            op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic                  ferr_q, ferr_d;
`ifdef PROG_VERIFY_EN
  logic                  dout_q, dout_d;
  logic                  fall;
  assign fall = ~clk_s2_q & clk_s3_q;
`endif

  logic               sample, cmd_done, data_done, frame_ok;
  logic [FRAME_W-1:0] frame;
  logic [5:0]         cmd_word;

  // Bits enter at the top, so after N shifts the first bit sits at FRAME_W-N.
  assign sample    = clk_s2_q & ~clk_s3_q;
  assign frame     = {dat_s2_q, sh_q[FRAME_W-1:1]};
  assign cmd_word  = frame[FRAME_W-1 -: 6];
  assign cmd_done  = (state_q == S_CMD) && sample && (cnt_q == 5'd5);
  assign data_done = (state_q == S_DATA) && sample && (cnt_q == 5'(FRAME_W - 1));
  assign frame_ok  = ~frame[0] && (frame[FRAME_W-1 -: 3] == 3'b000);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!prog_s2_q) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_CMD;
        S_CMD: begin
          if (cmd_done) begin
            case (cmd_word)
              OP_LOAD:                    state_d = S_DATA;
              OP_INC, OP_BEGIN, OP_RADDR: state_d = S_EXEC;
`ifdef PROG_VERIFY_EN
              OP_READ:                    state_d = S_EXEC;
`endif
              default:                    state_d = S_CMD;
            endcase
          end
        end
        S_DATA: if (data_done) state_d = S_CMD;
`ifdef PROG_VERIFY_EN
        S_EXEC:  state_d = (op_q == OP_READ) ? S_RDOUT : S_CMD;
        S_RDOUT: if (fall && cnt_q == 5'(FRAME_W - 1)) state_d = S_CMD;
`else
        S_EXEC:  state_d = S_CMD;
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    memWrEn  = (state_q == S_EXEC) && (op_q == OP_BEGIN);
    coreHold = prog_s2_q;
  end

  // Shifting is gated by progEn_s so a bit landing on the abort cycle is discarded.
  always_comb begin
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ferr_d  = ferr_q;
`ifdef PROG_VERIFY_EN
    dout_d  = dout_q;
`endif
    if (state_q == S_IDLE) begin
      addr_d = '0;
      cnt_d  = '0;
      sh_d   = '0;
      if (prog_s2_q) ferr_d = 1'b0;
    end else if (prog_s2_q) begin
      case (state_q)
        S_CMD: begin
          if (sample) begin
            sh_d  = frame;
            cnt_d = cnt_q + 5'd1;
            if (cmd_done) begin
              cnt_d = '0;
              op_d  = cmd_word;
            end
          end
        end
        S_DATA: begin
          if (sample) begin
            sh_d  = frame;
            cnt_d = cnt_q + 5'd1;
            if (data_done) begin
              cnt_d = '0;
              if (frame_ok) wdata_d = frame[WORD_WIDTH:1];
              else          ferr_d  = 1'b1;
            end
          end
        end
        S_EXEC: begin
          case (op_q)
            OP_INC:   addr_d = addr_q + 1'b1;
            OP_RADDR: addr_d = '0;
`ifdef PROG_VERIFY_EN
            OP_READ: begin
              sh_d  = {3'b000, memRdData, 1'b0};
              cnt_d = '0;
            end
`endif
            default: ;
          endcase
        end
`ifdef PROG_VERIFY_EN
        S_RDOUT: begin
          if (fall) begin
            dout_d = sh_q[0];
            sh_d   = sh_q >> 1;
            cnt_d  = (cnt_q == 5'(FRAME_W - 1)) ? 5'd0 : cnt_q + 5'd1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prog_s1_q <= 1'b0;
      prog_s2_q <= 1'b0;
      clk_s1_q  <= 1'b0;
      clk_s2_q  <= 1'b0;
      clk_s3_q  <= 1'b0;
      dat_s1_q  <= 1'b0;
      dat_s2_q  <= 1'b0;
      sh_q      <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      ferr_q    <= 1'b0;
`ifdef PROG_VERIFY_EN
      dout_q    <= 1'b0;
`endif
    end else begin
      prog_s1_q <= progEn;
      prog_s2_q <= prog_s1_q;
      clk_s1_q  <= icspClk;
      clk_s2_q  <= clk_s1_q;
      clk_s3_q  <= clk_s2_q;
      dat_s1_q  <= icspData;
      dat_s2_q  <= dat_s1_q;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      ferr_q    <= ferr_d;
`ifdef PROG_VERIFY_EN
      dout_q    <= dout_d;
`endif
    end
  end

  assign memAddr   = addr_q;
  assign memWrData = wdata_q;
  assign frameErr  = ferr_q;
`ifdef PROG_VERIFY_EN
  assign icspDataOut = dout_q;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - randomized self-checking bench for prog_loader against a command-level model.
`timescale 1ns/1ps
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst, progEn, icspClk, icspData;
  logic        memWrEn, coreHold, frameErr;
  logic [8:0]  memAddr;
  logic [11:0] memWrData;
`ifdef PROG_VERIFY_EN
  logic [11:0] memRdData;
  logic        icspDataOut;
`endif

  always #5 clk = ~clk;

  prog_loader #(.ADDR_WIDTH(9), .WORD_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .progEn(progEn), .icspClk(icspClk), .icspData(icspData),
`ifdef PROG_VERIFY_EN
    .memRdData(memRdData), .icspDataOut(icspDataOut),
`endif
    .memWrEn(memWrEn), .memAddr(memAddr), .memWrData(memWrData),
    .coreHold(coreHold), .frameErr(frameErr)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observed write strobes, counted per high cycle so a stretched pulse shows up.
  int          wr_cnt = 0;
  logic [8:0]  last_addr = '0;
  logic [11:0] last_data = '0;
  always @(negedge clk) begin
    if (memWrEn === 1'b1) begin
      wr_cnt++;
      last_addr = memAddr;
      last_data = memWrData;
    end
  end

  // Command-level reference model.
  int          m_addr = 0;
  logic [11:0] m_wdata = '0;
  logic        m_ferr = 1'b0;
  int          m_wr = 0;
  int          m_la = 0;
  logic [11:0] m_ld = '0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    icspData = b;
    tick(2);
    icspClk = 1'b1;
    tick(4);
    icspClk = 1'b0;
    tick(3);
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[i]);
  endtask

  task automatic do_cmd(input logic [5:0] c);
    send_bits({10'd0, c}, 6);
    case (c)
      6'h06: m_addr = (m_addr + 1) % 512;
      6'h00: m_addr = 0;
      6'h08: begin m_wr++; m_la = m_addr; m_ld = m_wdata; end
      default: ;
    endcase
  endtask

  task automatic do_load(input logic [11:0] w, input logic st, input logic [2:0] sp);
    logic [15:0] f;
    f = {sp, w, st};
    send_bits(16'h0002, 6);
    send_bits(f, 16);
    if (!st && sp == 3'b000) m_wdata = w;
    else                     m_ferr = 1'b1;
  endtask

  task automatic check_all();
    chk("addr", memAddr, m_addr);
    chk("wdata", memWrData, m_wdata);
    chk("ferr", frameErr, m_ferr);
    chk("hold", coreHold, 1);
    chk("wren_idle", memWrEn, 0);
    chk("wrcnt", wr_cnt, m_wr);
    if (m_wr > 0) begin
      chk("wr_addr", last_addr, m_la);
      chk("wr_data", last_data, m_ld);
    end
  endtask

  task automatic model_reset();
    m_addr = 0;
    m_wdata = '0;
    m_ferr = 1'b0;
  endtask

  initial begin
    logic [5:0] c;
    int r;
    rst = 1'b1; progEn = 1'b0; icspClk = 1'b0; icspData = 1'b0;
`ifdef PROG_VERIFY_EN
    memRdData = 12'h3F0;
`endif
    tick(3);
    chk("rst_wren", memWrEn, 0);
    chk("rst_addr", memAddr, 0);
    chk("rst_wdata", memWrData, 0);
    chk("rst_hold", coreHold, 0);
    chk("rst_ferr", frameErr, 0);
    rst = 1'b0;

    progEn = 1'b1;
    tick(1);
    chk("hold_lat1", coreHold, 0);
    tick(1);
    chk("hold_lat2", coreHold, 1);
    tick(2);

    do_load(12'hA5C, 1'b0, 3'b000);
    do_cmd(6'h08);
    check_all();

    repeat (511) do_cmd(6'h06);
    chk("addr_511", memAddr, 511);
    do_cmd(6'h06);
    chk("addr_wrap", memAddr, 0);
    repeat (3) do_cmd(6'h06);
    chk("addr_inc3", memAddr, 3);
    do_cmd(6'h00);
    check_all();

    do_load(12'h123, 1'b1, 3'b000);
    check_all();
    progEn = 1'b0;
    tick(6);
    chk("ferr_kept", frameErr, 1);
    progEn = 1'b1;
    tick(6);
    model_reset();
    m_wdata = 12'hA5C;
    check_all();

`ifndef PROG_VERIFY_EN
    do_cmd(6'h04);
    check_all();
`endif

    do_cmd(6'h06);
    do_cmd(6'h06);
    send_bits(16'h0002, 6);
    send_bits(16'h0BDE, 8);
    progEn = 1'b0;
    tick(6);
    chk("abort_addr", memAddr, 0);
    chk("abort_hold", coreHold, 0);
    chk("abort_wrcnt", wr_cnt, m_wr);
    chk("abort_wdata", memWrData, m_wdata);
    progEn = 1'b1;
    tick(4);
    m_addr = 0;
    do_load(12'h5E7, 1'b0, 3'b000);
    do_cmd(6'h08);
    check_all();

    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1: do_load(12'($urandom), 1'b0, 3'b000);
        2:    do_load(12'($urandom), 1'($urandom), 3'($urandom_range(1, 7)));
        3:    do_load(12'($urandom), 1'b1, 3'b000);
        4, 5: do_cmd(6'h06);
        6, 7: do_cmd(6'h08);
        8:    do_cmd(6'h00);
        default: begin
          c = 6'($urandom);
          while (c == 6'h00 || c == 6'h02 || c == 6'h04 || c == 6'h06 || c == 6'h08)
            c = 6'($urandom);
          do_cmd(c);
        end
      endcase
      check_all();
    end

    send_bits(16'h0002, 6);
    send_bits(16'h0FFF, 5);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    model_reset();
    chk("mrst_wren", memWrEn, 0);
    chk("mrst_addr", memAddr, 0);
    chk("mrst_wdata", memWrData, 0);
    chk("mrst_hold", coreHold, 0);
    chk("mrst_ferr", frameErr, 0);
    tick(4);
    do_cmd(6'h06);
    do_load(12'h3C7, 1'b0, 3'b000);
    do_cmd(6'h08);
    check_all();

`ifdef PROG_VERIFY_EN
    begin
      logic [15:0] vf;
      vf = {3'b000, 12'h3F0, 1'b0};
      send_bits(16'h0004, 6);
      chk("rd_bit0", icspDataOut, vf[0]);
      for (int i = 1; i < 16; i++) begin
        send_bit(1'b0);
        chk("rd_bit", icspDataOut, vf[i]);
      end
      do_cmd(6'h06);
      check_all();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Serial in-circuit program-memory loader for the PIC16C5x core. It receives a two-wire (clock/data) programming stream from an external programmer, decodes 6-bit commands and 16-bit data frames, and drives a synchronous write port into the program memory. The core only ever reads this memory; this block is the writer on that same memory interface. While programming mode is active, it holds the core in reset.

## Interface
- `ADDR_WIDTH`, 9: program-memory address width (512 words).
- `WORD_WIDTH`, 12: instruction word width.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `progEn`  in  1  programming-mode enable (asynchronous pin; synchronized internally).
- `icspClk`  in  1  programmer serial clock (asynchronous; synchronized internally).
- `icspData`  in  1  programmer serial data, LSB first, sampled on `icspClk` rising edge.
- `memWrEn`  out  1  one-cycle program-memory write strobe.
- `memAddr`  out  ADDR_WIDTH  program-memory address.
- `memWrData`  out  WORD_WIDTH  program-memory write data.
- `coreHold`  out  1  high while synchronized `progEn` = 1; feeds the core's reset.
- `frameErr`  out  1  sticky frame-error flag.

## Operation
- Synchronizers: 2-flop on `progEn`, `icspClk`, `icspData`. A sample event is a rising edge of synchronized `icspClk`, i.e. a 0→1 transition between sync stage 2 and a 3rd history flop. Data is taken from synchronized `icspData` in the same cycle.
- FSM states: IDLE, CMD, DATA, EXEC.
  - IDLE: entered while `progEn_s` = 0. `memAddr` is cleared to 0. Moves to CMD when `progEn_s` = 1.
  - CMD: shifts 6 bits, LSB first. After the 6th bit, decode:
    - 0x02 LOAD_DATA → DATA.
    - 0x06 INC_ADDR → EXEC.
    - 0x08 BEGIN_PROG → EXEC.
    - 0x00 RESET_ADDR → EXEC.
    - Any other code → CMD, ignored.
  - DATA: shifts 16 bits, LSB first. Frame layout: bit0 = start (0), bits12:1 = word, bits15:13 = stop (000).
    - Valid frame: latch the word into `memWrData`.
    - Invalid start or stop bits: keep `memWrData`, set `frameErr`.
    - Either way, return to CMD.
  - EXEC: single cycle, then return to CMD.
    - INC_ADDR: `memAddr` + 1, mod 2^ADDR_WIDTH; 511 wraps to 0.
    - BEGIN_PROG: `memWrEn` = 1 for exactly this cycle, with the current `memAddr` and `memWrData`.
    - RESET_ADDR: `memAddr` = 0.
- `progEn_s` falling in any state: return to IDLE next cycle and discard partial shifts. `memWrData` and `frameErr` are retained.
- `frameErr` clears only on `rst` or when `progEn_s` rises.
- BEGIN_PROG without a prior LOAD_DATA writes the current `memWrData` (0 after reset).

## Timing
- Reset values: `memWrEn` = 0, `memAddr` = 0, `memWrData` = 0, `coreHold` = 0, `frameErr` = 0, FSM = IDLE, shift counters = 0.
- `rst` takes precedence over every other event, mid-frame included.
- Pin-to-sample latency is 3 `clk` cycles from an `icspClk` rise to the bit being shifted.
- `memWrEn` asserts 1 cycle after the sample event of the 6th BEGIN_PROG bit.
- `memAddr` updates 1 cycle after the 6th INC_ADDR or RESET_ADDR bit.
- `coreHold` follows `progEn` with 2-cycle latency.
- `icspClk` high and low times must each be ≥ 3 `clk` cycles. Faster toggling is unsupported and bits may be lost.
- A sample event arriving during EXEC is not dropped: EXEC lasts one cycle and the next sample cannot occur within 3 cycles.

## Configuration
- `PROG_VERIFY_EN` defined:
  - Adds input `memRdData` [WORD_WIDTH-1:0] and output `icspDataOut` (1, reset 0).
  - Command 0x04 READ_DATA: captures `memRdData` at `memAddr` in EXEC, then moves to state RDOUT.
  - RDOUT shifts out the 16-bit frame {3'b000, word, 1'b0}, LSB first. Each bit is driven on `icspDataOut` after a falling edge of synchronized `icspClk`.
  - RDOUT returns to CMD after 16 falling edges.
- `PROG_VERIFY_EN` not defined: no such ports; 0x04 is ignored like any undefined code.

## Test plan
- Reset: hold `rst` 2 cycles mid-DATA frame → all outputs return to reset values; the next command decodes cleanly.
- Load/program: `progEn` = 1, LOAD_DATA with word 0xA5C, BEGIN_PROG → exactly one `memWrEn` pulse with `memAddr` = 0, `memWrData` = 0xA5C; `coreHold` = 1 throughout.
- Increment/wrap: 511× INC_ADDR → `memAddr` = 511; one more → 0; then RESET_ADDR after 3× INC_ADDR → `memAddr` = 0.
- Frame error: LOAD_DATA with start bit = 1 and word 0x123 → `frameErr` = 1 and `memWrData` unchanged. Toggle `progEn` → `frameErr` = 0.
- Abort: drop `progEn` after 8 data bits → IDLE, `memAddr` = 0, no `memWrEn`; the next session programs normally.
- Verify (`PROG_VERIFY_EN`): `memRdData` = 0x3F0, READ_DATA → `icspDataOut` emits 0, then bits of 0x3F0 LSB first, then 000.
